alu_driver: RTL and testbench
=============================

ALU_DRIVER -- requirements
Module: alu_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 18, operand/result width in bits.
REQ-002 SHALL have parameter ALU_LAT, default 2, the number of clk cycles from operand change to valid ALU result; legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  upstream offers an operand pair.
REQ-006 cmd_ready  output  1  block can accept a command.
REQ-007 cmd_a / cmd_b  input  WIDTH each  operands offered with cmd_valid.
REQ-008 A / B  output  WIDTH each  operands driven to the ALU A/B ports.
REQ-009 ALU_out  input  WIDTH  result from the ALU.
REQ-010 ovf / isZero  input  1 each  ALU overflow and zero flags.
REQ-011 res_valid  output  1  captured result available.
REQ-012 res_ready  input  1  downstream accepts the result.
REQ-013 res_data  output  WIDTH; res_ovf, res_zero  output  1 each  captured ALU_out, ovf, isZero.
REQ-014 ovf_count  output  8  saturating count of captured overflows.
REQ-015 zero_err  output  1  sticky flag: isZero disagreed with ALU_out.

Function
REQ-016 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-017 cmd_ready SHALL equal (state==IDLE) and SHALL be 0 while rst is high.
REQ-018 IDLE: on cmd_valid&&cmd_ready at edge E0, SHALL register A<=cmd_a, B<=cmd_b, clear the wait counter, and enter WAIT; otherwise remain in IDLE.
REQ-019 WAIT: SHALL count clk edges; at edge E0+ALU_LAT SHALL capture ALU_out, ovf, and isZero into res_data, res_ovf, and res_zero, set res_valid, and enter RESP.
REQ-020 res_valid SHALL therefore first be high in the cycle after edge E0+ALU_LAT (latency ALU_LAT cycles from accept).
REQ-021 cmd_valid, cmd_a, and cmd_b SHALL be ignored outside IDLE; A and B SHALL stay constant in WAIT and RESP.
REQ-022 RESP: res_valid, res_data, res_ovf, and res_zero SHALL hold stable until res_valid&&res_ready is sampled at an edge; at that edge res_valid<=0 and the state SHALL return to IDLE.
REQ-023 No same-cycle command accept on result handoff; cmd_ready rises the cycle after the handoff edge (minimum ALU_LAT+2 cycles per command).
REQ-024 res_ready asserted while res_valid is low SHALL have no effect.
REQ-025 A and B SHALL retain the last operands after an operation completes until the next accept.
REQ-026 At the capture edge, if ovf=1, ovf_count SHALL increment by 1, saturating at 255 with no wrap.
REQ-027 At the capture edge, if isZero != (ALU_out==0), zero_err SHALL set to 1 and remain set until reset.
REQ-028 All arithmetic SHALL be unsigned; the wait counter SHALL be 4 bits wide.

Reset
REQ-029 On rst high, SHALL immediately (asynchronously) enter IDLE and clear A, B, res_data, res_ovf, res_zero, res_valid, ovf_count, zero_err, and the wait counter to 0.
REQ-030 Reset during WAIT or RESP SHALL abort the operation; no res_valid SHALL follow for the aborted command.
REQ-031 The first command SHALL be accepted no earlier than the first rising edge after rst deasserts.

Verification
REQ-032 Basic: ALU stub returns registered A+B (ALU_LAT=2); cmd_a=14, cmd_b=16 accepted at E0 -> A=14, B=16 after E0; res_valid high after E0+2 with res_data=30, res_ovf=0, res_zero=0.
REQ-033 Backpressure: hold res_ready=0 for 5 cycles after res_valid -> res_data stays 30, cmd_ready stays 0; a new cmd_valid presented during this time is ignored; raise res_ready -> handoff, cmd_ready=1 the next cycle.
REQ-034 Zero/overflow: cmd_a=18'h3FFFF, cmd_b=1 -> res_data=0, res_ovf=1, res_zero=1, ovf_count=1, zero_err=0.
REQ-035 Saturation/err: 300 overflowing commands -> ovf_count=255; stub forcing isZero=1 with ALU_out=5 -> zero_err=1, stays 1 on later good results.
REQ-036 Reset mid-op: assert rst one cycle after accept -> all outputs 0 immediately; after release, no res_valid appears; the next command completes normally.

Source files
------------

// File: rtl/alu_driver.sv
// Drives operands to a fixed-latency ALU and captures its result and flags.
// Latency: result valid ALU_LAT cycles after command accept; one command in flight.
// Backpressure: result held until res_ready; cmd_ready low from accept until the cycle after handoff.
module alu_driver #(
    parameter int WIDTH   = 18,
    parameter int ALU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] ALU_out,
    input  logic             ovf,
    input  logic             isZero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_ovf,
    output logic             res_zero,
    output logic [7:0]       ovf_count,
    output logic             zero_err
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] dat;
        logic             ovf;
        logic             zero;
    } res_t;

    // Counter value seen at the edge where the ALU output is due.
    localparam logic [3:0] LAT_LAST = 4'(ALU_LAT - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [3:0]       cnt_q, cnt_d;
    res_t             res_q, res_d;
    logic             res_vld_q, res_vld_d;
    logic [7:0]       ovf_cnt_q, ovf_cnt_d;
    logic             zero_err_q, zero_err_d;
    logic             cmd_rdy;

    assign cmd_rdy = (state_q == IDLE) && !rst;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        res_vld_d  = res_vld_q;
        ovf_cnt_d  = ovf_cnt_q;
        zero_err_d = zero_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_rdy) begin
                    a_d     = cmd_a;
                    b_d     = cmd_b;
                    cnt_d   = 4'd0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == LAT_LAST) begin
                    res_d.dat = ALU_out;
                    res_d.ovf  = ovf;
                    res_d.zero = isZero;
                    res_vld_d  = 1'b1;
                    state_d    = RESP;
                    if (ovf && (ovf_cnt_q != 8'hFF)) begin
                        ovf_cnt_d = ovf_cnt_q + 8'd1;
                    end
                    if (isZero != (ALU_out == '0)) begin
                        zero_err_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                if (res_ready) begin
                    res_vld_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            res_q      <= '0;
            res_vld_q  <= 1'b0;
            ovf_cnt_q  <= '0;
            zero_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            cnt_q      <= cnt_d;
            res_q      <= res_d;
            res_vld_q  <= res_vld_d;
            ovf_cnt_q  <= ovf_cnt_d;
            zero_err_q <= zero_err_d;
        end
    end

    assign cmd_ready = cmd_rdy;
    assign A         = a_q;
    assign B         = b_q;
    assign res_valid = res_vld_q;
    assign res_data  = res_q.dat;
    assign res_ovf   = res_q.ovf;
    assign res_zero  = res_q.zero;
    assign ovf_count = ovf_cnt_q;
    assign zero_err  = zero_err_q;

endmodule

// File: tb/tb_alu_driver.sv
// Directed bench for alu_driver against a registered A+B ALU stub.
module tb_alu_driver;
    localparam int W   = 18;
    localparam int LAT = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_a = '0, cmd_b = '0;
    logic [W-1:0] A, B;
    logic [W-1:0] ALU_out;
    logic         ovf, isZero;
    logic         res_valid;
    logic         res_ready = 1'b0;
    logic [W-1:0] res_data;
    logic         res_ovf, res_zero;
    logic [7:0]   ovf_count;
    logic         zero_err;

    int n_checks = 0;
    int n_pass   = 0;

    // ALU stub: result registered one cycle after A/B, carry as overflow.
    logic [W-1:0] alu_q;
    logic         ovf_q;
    bit           force_bad = 1'b0;
    always @(posedge clk) {ovf_q, alu_q} <= {1'b0, A} + {1'b0, B};
    assign ALU_out = alu_q;
    assign ovf     = ovf_q;
    assign isZero  = force_bad ? 1'b1 : (alu_q == '0);

    always #5 clk = ~clk;

    alu_driver #(.WIDTH(W), .ALU_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b),
        .A(A), .B(B),
        .ALU_out(ALU_out), .ovf(ovf), .isZero(isZero),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_ovf(res_ovf), .res_zero(res_zero),
        .ovf_count(ovf_count), .zero_err(zero_err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] data;
        logic         ovf;
        logic         zero;
        int           cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit chk);
        int cyc = 0;
        while (!cmd_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        if (chk) begin
            check("A_after_accept", 32'(A), 32'(a));
            check("B_after_accept", 32'(B), 32'(b));
            check("cmd_ready_busy", 32'(cmd_ready), 32'd0);
        end
    endtask

    task automatic wait_res(input bit chk);
        int cyc = 0;
        while (!res_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!res_valid) check("res_valid_timeout", 32'(res_valid), 32'd1);
        else if (chk) check("latency", 32'(cyc), 32'(LAT));
    endtask

    task automatic handoff(input bit chk);
        if (chk) check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        if (chk) begin
            check("res_valid_after_handoff", 32'(res_valid), 32'd0);
            check("cmd_ready_after_handoff", 32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        bit seen;
        vecs[0] = '{a: 18'd14,     b: 18'd16,     data: 18'd30,     ovf: 1'b0, zero: 1'b0, cnt: 0};
        vecs[1] = '{a: 18'h3FFFF,  b: 18'd1,      data: 18'd0,      ovf: 1'b1, zero: 1'b1, cnt: 1};
        vecs[2] = '{a: 18'd0,      b: 18'd0,      data: 18'd0,      ovf: 1'b0, zero: 1'b1, cnt: 1};
        vecs[3] = '{a: 18'h20000,  b: 18'h20000,  data: 18'd0,      ovf: 1'b1, zero: 1'b1, cnt: 2};
        vecs[4] = '{a: 18'h3FFFF,  b: 18'h3FFFF,  data: 18'h3FFFE,  ovf: 1'b1, zero: 1'b0, cnt: 3};
        vecs[5] = '{a: 18'h12345,  b: 18'h0ABCD,  data: 18'h1CF12,  ovf: 1'b0, zero: 1'b0, cnt: 3};
        vecs[6] = '{a: 18'h1FFFF,  b: 18'd1,      data: 18'h20000,  ovf: 1'b0, zero: 1'b0, cnt: 3};

        // Reset state, with a command already offered
        cmd_valid = 1'b1;
        cmd_a = 18'd99;
        cmd_b = 18'd1;
        @(negedge clk);
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_A", 32'(A), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        check("rst_zero_err", 32'(zero_err), 32'd0);
        cmd_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);
        check("idle_no_accept_A", 32'(A), 32'd0);

        for (int i = 0; i < 7; i++) begin
            send(vecs[i].a, vecs[i].b, 1'b1);
            wait_res(1'b1);
            check($sformatf("v%0d_res_data", i), 32'(res_data), 32'(vecs[i].data));
            check($sformatf("v%0d_res_ovf", i), 32'(res_ovf), 32'(vecs[i].ovf));
            check($sformatf("v%0d_res_zero", i), 32'(res_zero), 32'(vecs[i].zero));
            check($sformatf("v%0d_ovf_count", i), 32'(ovf_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_zero_err", i), 32'(zero_err), 32'd0);
            handoff(1'b1);
            check($sformatf("v%0d_A_retained", i), 32'(A), 32'(vecs[i].a));
        end

        // Backpressure: result held, new command ignored
        send(18'd14, 18'd16, 1'b1);
        wait_res(1'b1);
        for (int i = 0; i < 5; i++) begin
            cmd_valid = 1'b1;
            cmd_a = 18'd500;
            cmd_b = 18'd600;
            @(negedge clk);
            check($sformatf("bp%0d_res_data", i), 32'(res_data), 32'd30);
            check($sformatf("bp%0d_res_valid", i), 32'(res_valid), 32'd1);
            check($sformatf("bp%0d_cmd_ready", i), 32'(cmd_ready), 32'd0);
            check($sformatf("bp%0d_A", i), 32'(A), 32'd14);
        end
        cmd_valid = 1'b0;
        handoff(1'b1);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("bp_no_ghost_result", 32'(seen), 32'd0);
        check("bp_A_unchanged", 32'(A), 32'd14);

        // Saturation of the overflow counter
        for (int i = 0; i < 300; i++) begin
            send(18'h3FFFF, 18'd1, 1'b0);
            wait_res(1'b0);
            handoff(1'b0);
        end
        check("sat_ovf_count", 32'(ovf_count), 32'd255);

        // Flag disagreement sets a sticky error
        force_bad = 1'b1;
        send(18'd2, 18'd3, 1'b0);
        wait_res(1'b1);
        check("bad_res_data", 32'(res_data), 32'd5);
        check("bad_res_zero", 32'(res_zero), 32'd1);
        check("bad_zero_err", 32'(zero_err), 32'd1);
        handoff(1'b0);
        force_bad = 1'b0;
        send(18'd4, 18'd4, 1'b0);
        wait_res(1'b0);
        check("good_res_data", 32'(res_data), 32'd8);
        check("zero_err_sticky", 32'(zero_err), 32'd1);
        check("ovf_count_still_sat", 32'(ovf_count), 32'd255);
        handoff(1'b0);

        // Reset one cycle after accept aborts the command
        send(18'd7, 18'd9, 1'b0);
        rst = 1'b1;
        #1;
        check("mid_rst_A", 32'(A), 32'd0);
        check("mid_rst_B", 32'(B), 32'd0);
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_ovf_count", 32'(ovf_count), 32'd0);
        check("mid_rst_zero_err", 32'(zero_err), 32'd0);
        check("mid_rst_res_data", 32'(res_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check("aborted_no_result", 32'(seen), 32'd0);
        send(18'd7, 18'd9, 1'b1);
        wait_res(1'b1);
        check("post_rst_res_data", 32'(res_data), 32'd16);
        check("post_rst_res_ovf", 32'(res_ovf), 32'd0);
        handoff(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
